control_unit: RTL and testbench
===============================

# control_unit

Sequencer that drives the `MAX_CONTROL_LINES`-wide control vector of `data_path`. It consumes the 4-bit opcode (`IR`) and zero flag (`Z`) that `data_path` returns. It runs a fetch / decode / execute loop and issues memory read/write strobes with a ready handshake. Together with `data_path` and memory it forms the complete MMA processor.

## Interface
- Parameters: none. Control-line indices come from `controlSignal.v`. Besides the existing lines, that file defines `ABUS_R0`, which drives `abus` from R0[11:0].
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: reset, synchronous and active-high.
- `IR` in 4: opcode from `data_path`.
- `Z` in 1: zero flag from `data_path`.
- `mem_ready` in 1: memory completion for the current `mem_rd`/`mem_wr`.
- `control` out [0:`MAX_CONTROL_LINES-1]: control vector to `data_path`.
- `mem_rd` out 1: memory read request; address is on `abus`.
- `mem_wr` out 1: memory write request; data is on `wbus`.
- `halted` out 1: high in HALT.

## Operation
- Instruction word is 16 bits: [15:12] opcode, [11:0] operand address.
- Opcodes:
  - 0 NOP
  - 1 LOAD (ACC←M[a])
  - 2 STORE (M[a]←ACC)
  - 3 ADD (ACC←ACC+M[a], Z updated)
  - 4 JMP (PC←a)
  - 5 JZ (PC←a if Z=1)
  - F HALT
  - All other opcodes (6–E) execute as NOP.
- Moore machine: `control`, `mem_rd`, `mem_wr` and `halted` decode from the state register only. Any line not listed for a state is 0.
- States and asserted lines:
  - INIT: `INIT_PC` → FETCH.
  - FETCH: `ABUS_PC`, `IR_RBUS`, `R0_RBUS`, `mem_rd`. Stays while `mem_ready`=0; → DECODE on `mem_ready`=1. IR and R0 reload every cycle, so the value captured on the ready edge is the instruction.
  - DECODE: `INC_PC`. Next state by `IR`:
    - 1 → LD_RD
    - 2 → ST_WR
    - 3 → ADD_RD
    - 4 → JUMP
    - 5 → JUMP if `Z`=1, else FETCH
    - F → HALT
    - others → FETCH
  - LD_RD: `ABUS_R0`, `ACC_RBUS`, `mem_rd`. Waits for `mem_ready`, then → FETCH.
  - ST_WR: `ABUS_R0`, `WBUS_ACC`, `mem_wr`. Waits for `mem_ready`, then → FETCH.
  - ADD_RD: `ABUS_R0`, `mem_rd`. Waits for `mem_ready`, then → ADD_LD.
  - ADD_LD: `ABUS_R0`, `R0_RBUS`, `mem_rd`. Always → ADD_EX. Memory keeps `rbus` valid while address and `mem_rd` stay stable after ready.
  - ADD_EX: `ADD_OP`, `ACC_ALU` → FETCH.
  - JUMP: `PC_R0` → FETCH.
  - HALT: `halted`=1, no control lines asserted. Left only by `reset`.
- `mem_rd` and `mem_wr` are never high together. Each strobe holds steady, with a stable address, until `mem_ready` is sampled high.
- `mem_ready` seen in any state that has no strobe is ignored.
- JZ tests the `Z` value sampled on the DECODE→next edge. `Z` is produced by the last ALU operation (ADD).
- PC arithmetic is 12-bit and owned by `data_path`; PC wraps from FFF to 000 with no special handling here.

## Timing
- `reset` high at an edge forces INIT, from any state including mid-handshake. While the state is INIT, all outputs are 0 except `control[INIT_PC]`=1. `mem_rd`, `mem_wr` and `halted` are all 0.
- A mid-transfer reset drops the strobe on the next edge; memory must tolerate an abandoned request.
- Latency with `mem_ready` tied high:
  - NOP: 2 cycles (FETCH, DECODE)
  - LOAD: 3 cycles
  - STORE: 3 cycles
  - JMP: 3 cycles
  - JZ not taken: 2 cycles
  - JZ taken: 3 cycles
  - ADD: 5 cycles
- Each wait cycle with `mem_ready`=0 adds one cycle to FETCH, LD_RD, ST_WR or ADD_RD.
- First instruction fetch begins the cycle after INIT; PC=0 for that fetch.
- Outputs are stable from shortly after the rising edge until the next rising edge; `data_path` samples them on that next edge.

## Test plan
- Reset, then release with `mem_ready`=1 and memory = {0x1005, 0x3006, 0x2007, 0xF000}, M[5]=0x0003, M[6]=0x0004 → M[7]=0x0007, `halted`=1 after 2+3+5+3+1 cycles post-INIT.
- `mem_ready` held low 4 cycles during the first FETCH → `mem_rd`=1 and `ABUS_PC` asserted for all 5 cycles, IR latched only on the ready edge, then `INC_PC` exactly once.
- JZ with Z=1 (program: 0x1005 where M[5]=0, 0x3005, 0x5010) → `abus`=0x010 on the next fetch. Same program with M[5]=1 → next fetch at address 0x003.
- Opcodes 0x6..0xE each → one FETCH + DECODE, no strobes or data-moving lines, PC advances by 1.
- Assert `reset` in ST_WR while `mem_ready`=0 → next cycle INIT with `mem_wr`=0 and only `INIT_PC` high, then fetch from address 0.
- Over a random program with random `mem_ready` stalls → `mem_rd` and `mem_wr` never high together, and no control line other than `INIT_PC` is high during INIT.

Source files
------------

// File: rtl/control_unit.sv
// control_unit
// ------------
// Moore sequencer for the MMA processor. It runs the fetch / decode / execute
// loop and drives the control vector of data_path, plus the memory read and
// write strobes that complete with a ready handshake.
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   reset      in   synchronous, active-high; forces INIT from any state
//   IR         in   4-bit opcode returned by data_path
//   Z          in   zero flag returned by data_path (from the last ADD)
//   mem_ready  in   completion of the pending mem_rd / mem_wr
//   control    out  [0:MAX_CONTROL_LINES-1] control vector to data_path
//   mem_rd     out  memory read request, address on abus
//   mem_wr     out  memory write request, data on wbus
//   halted     out  high while in HALT
//
// The control-line indices normally come from controlSignal.v. The defaults
// below are used only when that file has not already defined them.

`ifndef MAX_CONTROL_LINES
`define MAX_CONTROL_LINES 11
`endif
`ifndef INIT_PC
`define INIT_PC  0
`endif
`ifndef ABUS_PC
`define ABUS_PC  1
`endif
`ifndef IR_RBUS
`define IR_RBUS  2
`endif
`ifndef R0_RBUS
`define R0_RBUS  3
`endif
`ifndef INC_PC
`define INC_PC   4
`endif
`ifndef ABUS_R0
`define ABUS_R0  5
`endif
`ifndef ACC_RBUS
`define ACC_RBUS 6
`endif
`ifndef WBUS_ACC
`define WBUS_ACC 7
`endif
`ifndef ADD_OP
`define ADD_OP   8
`endif
`ifndef ACC_ALU
`define ACC_ALU  9
`endif
`ifndef PC_R0
`define PC_R0    10
`endif

module control_unit (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     IR,
  input  logic                           Z,
  input  logic                           mem_ready,
  output logic [0:`MAX_CONTROL_LINES-1]  control,
  output logic                           mem_rd,
  output logic                           mem_wr,
  output logic                           halted
);

  // Opcodes that change the flow out of DECODE; everything else is a NOP.
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LD_RD  = 4'd3,
    S_ST_WR  = 4'd4,
    S_ADD_RD = 4'd5,
    S_ADD_LD = 4'd6,
    S_ADD_EX = 4'd7,
    S_JUMP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register. Reset wins over everything, including an open handshake;
  // the strobe then drops on the following edge and the request is abandoned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      // IR and R0 reload every FETCH cycle; the value present on the ready
      // edge is the one that is kept.
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (IR)
          OP_LOAD:  state_d = S_LD_RD;
          OP_STORE: state_d = S_ST_WR;
          OP_ADD:   state_d = S_ADD_RD;
          OP_JMP:   state_d = S_JUMP;
          OP_JZ:    state_d = Z ? S_JUMP : S_FETCH;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_LD_RD:  state_d = mem_ready ? S_FETCH : S_LD_RD;
      S_ST_WR:  state_d = mem_ready ? S_FETCH : S_ST_WR;
      S_ADD_RD: state_d = mem_ready ? S_ADD_LD : S_ADD_RD;
      // Memory holds rbus valid while address and mem_rd stay put, so the
      // operand is captured into R0 here without a second handshake.
      S_ADD_LD: state_d = S_ADD_EX;
      S_ADD_EX: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Output decode from the state register only (Moore).
  always_comb begin
    control = '0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        control[`INIT_PC] = 1'b1;
      end
      S_FETCH: begin
        control[`ABUS_PC] = 1'b1;
        control[`IR_RBUS] = 1'b1;
        control[`R0_RBUS] = 1'b1;
        mem_rd            = 1'b1;
      end
      S_DECODE: begin
        control[`INC_PC] = 1'b1;
      end
      S_LD_RD: begin
        control[`ABUS_R0]  = 1'b1;
        control[`ACC_RBUS] = 1'b1;
        mem_rd             = 1'b1;
      end
      S_ST_WR: begin
        control[`ABUS_R0]  = 1'b1;
        control[`WBUS_ACC] = 1'b1;
        mem_wr             = 1'b1;
      end
      S_ADD_RD: begin
        control[`ABUS_R0] = 1'b1;
        mem_rd            = 1'b1;
      end
      S_ADD_LD: begin
        control[`ABUS_R0] = 1'b1;
        control[`R0_RBUS] = 1'b1;
        mem_rd            = 1'b1;
      end
      S_ADD_EX: begin
        control[`ADD_OP]  = 1'b1;
        control[`ACC_ALU] = 1'b1;
      end
      S_JUMP: begin
        control[`PC_R0] = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        control = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// ---------------
// Directed bench for control_unit. A small behavioural data_path + memory
// closes the loop so real programs run; expected values are hand-computed.

module tb_control_unit;

  localparam int NL = 11;
  localparam int C_INIT_PC  = 0;
  localparam int C_ABUS_PC  = 1;
  localparam int C_IR_RBUS  = 2;
  localparam int C_R0_RBUS  = 3;
  localparam int C_INC_PC   = 4;
  localparam int C_ABUS_R0  = 5;
  localparam int C_ACC_RBUS = 6;
  localparam int C_WBUS_ACC = 7;
  localparam int C_ADD_OP   = 8;
  localparam int C_ACC_ALU  = 9;
  localparam int C_PC_R0    = 10;

  localparam logic [NL-1:0] M_INIT  = NL'(1) << C_INIT_PC;
  localparam logic [NL-1:0] M_FETCH = (NL'(1) << C_ABUS_PC) | (NL'(1) << C_IR_RBUS) | (NL'(1) << C_R0_RBUS);
  localparam logic [NL-1:0] M_DEC   = NL'(1) << C_INC_PC;
  localparam logic [NL-1:0] M_LD    = (NL'(1) << C_ABUS_R0) | (NL'(1) << C_ACC_RBUS);
  localparam logic [NL-1:0] M_ST    = (NL'(1) << C_ABUS_R0) | (NL'(1) << C_WBUS_ACC);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    ir_op;
  logic          z_flag = 1'b0;
  logic          mem_ready = 1'b1;
  logic [0:NL-1] control;
  logic          mem_rd;
  logic          mem_wr;
  logic          halted;

  always #5 clk = ~clk;

  control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .IR        (ir_op),
    .Z         (z_flag),
    .mem_ready (mem_ready),
    .control   (control),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .halted    (halted)
  );

  // ---------------- behavioural data_path + memory ----------------
  logic [11:0] pc;
  logic [15:0] ir_q = 16'h0;
  logic [15:0] r0 = 16'h0;
  logic [15:0] acc = 16'h0;
  logic [15:0] mem [0:4095];
  logic        clr_req = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = 12'h0;
  logic [15:0] ld_data = 16'h0;
  logic [NL-1:0] ctl;
  logic [11:0] abus;
  logic [15:0] rbus;
  logic [15:0] sum;

  always_comb begin
    ctl = '0;
    for (int i = 0; i < NL; i++) ctl[i] = control[i];
  end

  assign abus  = ctl[C_ABUS_PC] ? pc : (ctl[C_ABUS_R0] ? r0[11:0] : 12'h000);
  assign rbus  = mem[abus];
  assign ir_op = ir_q[15:12];
  assign sum   = acc + r0;

  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_wr && mem_ready) begin
      mem[abus] <= acc;
    end
    if (reset) begin
      ir_q   <= 16'h0;
      r0     <= 16'h0;
      acc    <= 16'h0;
      z_flag <= 1'b0;
    end else begin
      if (ctl[C_IR_RBUS])  ir_q <= rbus;
      if (ctl[C_R0_RBUS])  r0   <= rbus;
      if (ctl[C_ACC_RBUS]) acc  <= rbus;
      if (ctl[C_ADD_OP] && ctl[C_ACC_ALU]) begin
        acc    <= sum;
        z_flag <= (sum == 16'h0);
      end
    end
    if (ctl[C_INIT_PC])     pc <= 12'h000;
    else if (ctl[C_INC_PC]) pc <= pc + 12'h001;
    else if (ctl[C_PC_R0])  pc <= r0[11:0];
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    clr_req   = 1'b1;
    step();
    clr_req   = 1'b0;
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  // Drop reset; after this the DUT is in the first FETCH.
  task automatic release_rst(input logic rdy);
    mem_ready = rdy;
    reset     = 1'b0;
    step();
  endtask

  task automatic run_jz(input string tag, input logic [15:0] m5, input logic [11:0] exp_addr);
    int nf;
    bit found;
    begin_reset();
    load(12'h000, 16'h1005);
    load(12'h001, 16'h3005);
    load(12'h002, 16'h5010);
    load(12'h005, m5);
    release_rst(1'b1);
    nf = 0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (ctl[C_ABUS_PC]) begin
        nf++;
        if (nf == 4) begin
          check_eq(tag, 32'(abus), 32'(exp_addr));
          found = 1'b1;
        end
      end
      if (!found) step();
    end
    if (!found) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    $display("jz case %s done", tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1: reference program, ready tied high ----
    begin_reset();
    load(12'h000, 16'h1005);
    load(12'h001, 16'h3006);
    load(12'h002, 16'h2007);
    load(12'h003, 16'hF000);
    load(12'h005, 16'h0003);
    load(12'h006, 16'h0004);
    check_eq("init_ctl", 32'(ctl), 32'(M_INIT));
    check_eq("init_strobes", {29'd0, halted, mem_wr, mem_rd}, 32'd0);
    release_rst(1'b1);
    for (int k = 1; k <= 14; k++) begin
      if (k >= 13) check_eq($sformatf("prog_halt_c%0d", k), 32'(halted), 32'(k == 14));
      if (k < 14) step();
    end
    check_eq("prog_m7", 32'(mem[7]), 32'h0007);
    check_eq("halt_ctl", 32'(ctl), 32'd0);
    step(); step(); step();
    check_eq("halt_sticky", {30'd0, halted, mem_rd}, 32'b10);
    $display("program run done");

    // ---- 2: four-cycle stall on the first FETCH ----
    begin_reset();
    load(12'h000, 16'h1005);
    load(12'h005, 16'h00AB);
    release_rst(1'b0);
    for (int c = 1; c <= 5; c++) begin
      check_eq($sformatf("stall_rd_c%0d", c), 32'(mem_rd), 32'd1);
      check_eq($sformatf("stall_ctl_c%0d", c), 32'(ctl), 32'(M_FETCH));
      check_eq($sformatf("stall_abus_c%0d", c), 32'(abus), 32'd0);
      if (c == 5) mem_ready = 1'b1;
      step();
    end
    check_eq("stall_decode", 32'(ctl), 32'(M_DEC));
    check_eq("stall_ir", 32'(ir_q), 32'h1005);
    step();
    check_eq("stall_ld_ctl", 32'(ctl), 32'(M_LD));
    check_eq("stall_ld_abus", 32'(abus), 32'h005);
    step();
    check_eq("stall_pc", 32'(pc), 32'h001);
    check_eq("stall_acc", 32'(acc), 32'h00AB);
    $display("fetch stall done");

    // ---- 3: JZ taken / not taken ----
    run_jz("jz_taken", 16'h0000, 12'h010);
    run_jz("jz_not_taken", 16'h0001, 12'h003);

    // ---- 4: opcodes 6..E behave as NOP ----
    begin_reset();
    for (int i = 0; i < 9; i++) begin
      logic [3:0] o;
      o = 4'(i + 6);
      load(12'(i), {o, 12'h123});
    end
    load(12'h009, 16'hF000);
    release_rst(1'b1);
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("nop%0h_fetch_abus", i + 6), 32'(abus), 32'(i));
      check_eq($sformatf("nop%0h_fetch_ctl", i + 6), 32'(ctl), 32'(M_FETCH));
      step();
      check_eq($sformatf("nop%0h_decode", i + 6), {20'd0, mem_wr, mem_rd, 10'd0} | 32'(ctl), 32'(M_DEC));
      step();
    end
    step(); step();
    check_eq("nop_halted", 32'(halted), 32'd1);
    check_eq("nop_pc", 32'(pc), 32'h00A);
    $display("undefined opcodes done");

    // ---- 5: reset in the middle of a stalled STORE ----
    begin_reset();
    load(12'h000, 16'h2007);
    load(12'h007, 16'h5555);
    release_rst(1'b1);
    step();
    mem_ready = 1'b0;
    step();
    check_eq("st_ctl", 32'(ctl), 32'(M_ST));
    check_eq("st_wr", 32'(mem_wr), 32'd1);
    reset = 1'b1;
    step();
    check_eq("st_rst_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
    check_eq("st_rst_ctl", 32'(ctl), 32'(M_INIT));
    check_eq("st_rst_mem", 32'(mem[7]), 32'h5555);
    reset = 1'b0;
    mem_ready = 1'b1;
    step();
    check_eq("st_refetch_abus", 32'(abus), 32'h000);
    check_eq("st_refetch_rd", 32'(mem_rd), 32'd1);
    $display("reset during store done");

    // ---- 6: random program with random stalls and resets ----
    begin_reset();
    for (int a = 0; a < 64; a++) begin
      logic [3:0] o;
      logic [5:0] t;
      o = 4'($urandom_range(0, 14));
      t = 6'($urandom());
      load(12'(a), {o, 6'd0, t});
    end
    release_rst(1'b1);
    begin
      logic prev_rd, prev_wr, prev_rdy, prev_rst;
      logic [11:0] prev_abus;
      logic [NL-1:0] prev_ctl;
      prev_rd = 1'b0; prev_wr = 1'b0; prev_rdy = 1'b1; prev_rst = 1'b0;
      prev_abus = 12'h0; prev_ctl = '0;
      for (int c = 0; c < 3000; c++) begin
        check_eq("rnd_excl", 32'(mem_rd & mem_wr), 32'd0);
        if (prev_rst) begin
          check_eq("rnd_init_ctl", 32'(ctl), 32'(M_INIT));
          check_eq("rnd_init_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
        end else if ((prev_rd || prev_wr) && !prev_rdy &&
                     !(prev_ctl[C_ABUS_R0] && prev_ctl[C_R0_RBUS])) begin
          check_eq("rnd_hold_strobe", {30'd0, mem_wr, mem_rd}, {30'd0, prev_wr, prev_rd});
          check_eq("rnd_hold_abus", 32'(abus), 32'(prev_abus));
        end
        mem_ready = ($urandom_range(0, 3) != 0);
        reset     = ($urandom_range(0, 99) == 0);
        prev_rd   = mem_rd;
        prev_wr   = mem_wr;
        prev_rdy  = mem_ready;
        prev_rst  = reset;
        prev_abus = abus;
        prev_ctl  = ctl;
        step();
      end
    end
    reset = 1'b0;
    $display("random run done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
